// File: rtl/subtractor_serial_reg_pkg.sv
// Shared definitions for the chunk-serial registered subtractor:
// FSM state encoding and a counter-width helper.
package subtractor_serial_reg_pkg;

  // Default geometry: 32-bit operands processed 8 bits per cycle.
  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_CHUNK = 8;

  // Two-state sequencer: waiting for a request, or walking the chunks.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Bits needed to count 0..n-1. Never returns less than 1, so the
  // single-chunk case (n == 1) still gets a legal 1-bit counter.
  function automatic int cnt_width(input int n);
    int w;
    w = 1;
    for (int i = 0; i < 32; i++) begin
      if ((1 << w) < n) begin
        w = w + 1;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/subtractor_serial_reg_sub_chunk.sv
// Combinational CHUNK-bit adder slice used for one chunk of a + ~b + c.
// Also exposes the carry into its top bit so the top level can derive
// signed overflow on the final chunk.

// One-bit full adder cell used to build the chunk slice.
module sub_fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (x & ci) | (y & ci);

endmodule

module sub_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y_n,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  // carry[i] is the carry into bit i; carry[CHUNK] leaves the slice.
  logic [CHUNK:0] carry;

  assign carry[0] = cin;

  generate
    for (genvar gi = 0; gi < CHUNK; gi++) begin : g_fa
      sub_fa_cell u_fa (
        .x  (x[gi]),
        .y  (y_n[gi]),
        .ci (carry[gi]),
        .s  (s[gi]),
        .co (carry[gi+1])
      );
    end
  endgenerate

  assign cout     = carry[CHUNK];
  assign c_msb_in = carry[CHUNK-1];

endmodule

// File: rtl/subtractor_serial_reg.sv
// Multi-cycle registered subtractor: d = a - b - bi, processed CHUNK bits
// per clock through one shared chunk slice. A start/busy/done handshake
// sequences each operation; d/bo/ov only change on the done edge.
module subtractor_serial_reg
  import subtractor_serial_reg_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bi,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bo,
  output logic             ov
);

  // Number of chunk cycles per operation and the counter that walks them.
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  state_t            state_reg;
  logic [CW-1:0]     cnt_reg;
  logic [WIDTH-1:0]  a_reg;       // latched minuend
  logic [WIDTH-1:0]  b_n_reg;     // latched, already-inverted subtrahend
  logic              carry_reg;   // carry between successive chunks
  logic [WIDTH-1:0]  res_reg;     // partial result, never exposed directly
  logic [WIDTH-1:0]  res_next;
  logic [WIDTH-1:0]  d_reg;
  logic              bo_reg;
  logic              ov_reg;
  logic              done_reg;
  logic              busy_reg;

  logic [CHUNK-1:0]  chunk_x;
  logic [CHUNK-1:0]  chunk_y_n;
  logic [CHUNK-1:0]  chunk_s;
  logic              chunk_cout;
  logic              chunk_c_msb_in;

  // Select the chunk addressed by the counter from both operand registers.
  always_comb begin
    chunk_x   = a_reg[cnt_reg*CHUNK +: CHUNK];
    chunk_y_n = b_n_reg[cnt_reg*CHUNK +: CHUNK];
  end

  sub_chunk #(
    .CHUNK (CHUNK)
  ) u_sub_chunk (
    .x        (chunk_x),
    .y_n      (chunk_y_n),
    .cin      (carry_reg),
    .s        (chunk_s),
    .cout     (chunk_cout),
    .c_msb_in (chunk_c_msb_in)
  );

  // Merge the freshly computed chunk into the partial result so the final
  // chunk can load d directly without waiting an extra cycle.
  always_comb begin
    res_next = res_reg;
    res_next[cnt_reg*CHUNK +: CHUNK] = chunk_s;
  end

  // Sequencer, operand/carry/result registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      a_reg     <= '0;
      b_n_reg   <= '0;
      carry_reg <= 1'b0;
      res_reg   <= '0;
      d_reg     <= '0;
      bo_reg    <= 1'b0;
      ov_reg    <= 1'b0;
      done_reg  <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            a_reg     <= a;
            b_n_reg   <= ~b;
            carry_reg <= ~bi;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= ST_RUN;
          end
        end
        ST_RUN: begin
          res_reg   <= res_next;
          carry_reg <= chunk_cout;
          cnt_reg   <= cnt_reg + 1'b1;
          if (cnt_reg == CNT_LAST) begin
            // Last chunk: its carry out is the carry out of bit WIDTH-1.
            d_reg     <= res_next;
            bo_reg    <= ~chunk_cout;
            ov_reg    <= chunk_c_msb_in ^ chunk_cout;
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            cnt_reg   <= '0;
            state_reg <= ST_IDLE;
          end
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign d    = d_reg;
  assign bo   = bo_reg;
  assign ov   = ov_reg;

endmodule

// File: tb/tb_subtractor_serial_reg.sv
// Self-checking bench for subtractor_serial_reg with a result scoreboard.
module tb_subtractor_serial_reg;

  localparam int W = 32;
  localparam int C = 8;
  localparam int N = W / C;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bi = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] d;
  logic         bo;
  logic         ov;

  typedef struct packed {
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   txn = 0;

  always #5 clk = ~clk;

  subtractor_serial_reg #(
    .WIDTH (W),
    .CHUNK (C)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bi    (bi),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .bo    (bo),
    .ov    (ov)
  );

  // Reference: wide signed/unsigned arithmetic, independent of the chunk scheme.
  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbi);
    exp_t r;
    logic signed [W+1:0] sd;
    sd   = $signed({{2{ma[W-1]}}, ma}) - $signed({{2{mb[W-1]}}, mb}) - $signed({{(W+1){1'b0}}, mbi});
    r.d  = ma - mb - {{(W-1){1'b0}}, mbi};
    r.bo = ({1'b0, ma} < ({1'b0, mb} + {{W{1'b0}}, mbi}));
    r.ov = (sd[W+1:W-1] != 3'b000) && (sd[W+1:W-1] != 3'b111);
    return r;
  endfunction

  // Scoreboard: every done pulse pops one expectation and compares it.
  always @(negedge clk) begin
    if (rst_n && done) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got done=1 with d=%h, required no done", d);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        txn++;
        if ({d, bo, ov} !== {e.d, e.bo, e.ov}) begin
          errors++;
          $display("FAIL result: got d=%h bo=%b ov=%b, required d=%h bo=%b ov=%b",
                   d, bo, ov, e.d, e.bo, e.ov);
        end else begin
          $display("txn %0d: d=%h bo=%b ov=%b ok", txn, d, bo, ov);
        end
      end
    end
  end

  // Outputs must hold between done pulses.
  logic [W+1:0] prev_out = '0;
  always @(negedge clk) begin
    if (rst_n && !done) begin
      checks++;
      if ({d, bo, ov} !== prev_out) begin
        errors++;
        $display("FAIL hold: got d/bo/ov=%h, required held value %h", {d, bo, ov}, prev_out);
      end
    end
    prev_out = {d, bo, ov};
  end

  // Issue one operation at a negedge (DUT assumed idle) and return just after the accepting edge.
  task automatic drive_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbi);
    @(negedge clk);
    a = ta; b = tb_; bi = tbi; start = 1'b1;
    exp_q.push_back(model(ta, tb_, tbi));
    @(posedge clk);
    #1 start = 1'b0;
    a = $urandom; b = $urandom; bi = 1'b0;
  endtask

  // Count edges from the accepting edge until done is seen; -1 if the bound expires.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i - 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({busy, done, d, bo, ov} !== '0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b d=%h bo=%b ov=%b, required all 0",
               busy, done, d, bo, ov);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, d, bo, ov} !== '0) begin
      errors++;
      $display("FAIL idle_after_reset: got busy=%b done=%b d=%h, required all 0", busy, done, d);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] va [4] = '{32'd5, 32'd0, 32'h8000_0000, 32'h0000_0100};
    logic [W-1:0] vb [4] = '{32'd3, 32'd1, 32'd1, 32'd1};
    logic         vbi[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    int lat;
    for (int i = 0; i < 4; i++) begin
      drive_op(va[i], vb[i], vbi[i]);
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL busy_after_accept: got %b, required 1", busy);
      end
      wait_done(lat);
      checks++;
      if (lat !== N) begin
        errors++;
        $display("FAIL latency: got %0d, required %0d", lat, N);
      end
    end
  endtask

  task automatic test_random();
    int lat;
    for (int i = 0; i < 8; i++) begin
      drive_op($urandom, $urandom, 1'($urandom_range(0, 1)));
      wait_done(lat);
      checks++;
      if (lat !== N) begin
        errors++;
        $display("FAIL random_latency: got %0d, required %0d", lat, N);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    drive_op(32'h1234_5678, 32'h0000_FFFF, 1'b1);
    wait_done(lat);
    // Still in the done cycle: issue the next op with no gap.
    a = 32'h0000_0010; b = 32'h0000_0020; bi = 1'b0; start = 1'b1;
    exp_q.push_back(model(32'h0000_0010, 32'h0000_0020, 1'b0));
    @(posedge clk);
    #1 start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: got busy=%b, required 1", busy);
    end
    wait_done(lat);
    checks++;
    if (lat !== N) begin
      errors++;
      $display("FAIL b2b_latency: got %0d, required %0d", lat, N);
    end
  endtask

  task automatic test_busy_start();
    int   lat;
    exp_t e;
    e = model(32'hCAFE_0000, 32'h0000_BEEF, 1'b0);
    drive_op(32'hCAFE_0000, 32'h0000_BEEF, 1'b0);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) begin
        a = 32'h1111_1111; b = 32'h2222_2222; bi = 1'b1; start = 1'b1;
      end
      if (i == 3) start = 1'b0;
      if (done) begin
        lat = i - 1;
        break;
      end
    end
    checks++;
    if (lat !== N) begin
      errors++;
      $display("FAIL busy_start_latency: got %0d, required %0d", lat, N);
    end
    repeat (N + 2) @(negedge clk);
    checks++;
    if ({busy, d, bo, ov} !== {1'b0, e.d, e.bo, e.ov}) begin
      errors++;
      $display("FAIL busy_start_ignored: got busy=%b d=%h bo=%b ov=%b, required busy=0 d=%h bo=%b ov=%b",
               busy, d, bo, ov, e.d, e.bo, e.ov);
    end
  endtask

  task automatic test_reset_mid_op();
    int lat;
    int seen_done;
    drive_op(32'h0F0F_0F0F, 32'h0000_0001, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, d, bo, ov} !== '0) begin
      errors++;
      $display("FAIL reset_mid_op: got busy=%b done=%b d=%h bo=%b ov=%b, required all 0",
               busy, done, d, bo, ov);
    end
    exp_q.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    seen_done = 0;
    repeat (N + 2) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    checks++;
    if (seen_done !== 0) begin
      errors++;
      $display("FAIL no_done_after_reset: got %0d pulses, required 0", seen_done);
    end
    drive_op(32'h0000_0000, 32'h0000_0000, 1'b1);
    wait_done(lat);
    checks++;
    if (lat !== N) begin
      errors++;
      $display("FAIL post_reset_latency: got %0d, required %0d", lat, N);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_busy_start();
    test_reset_mid_op();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending results, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
